// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing a single uart_tx transmitter between N byte
// requesters. Grants are held for bounded bursts, and each frame start is
// supervised so that a transmitter that never reports busy cannot stall the line.
`timescale 1ns/1ps
module uart_tx_arbiter #(
  parameter int N         = 4,
  parameter int MAX_BURST = 8,
  parameter int START_TO  = 4
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic [N-1:0]   req_valid_i,
  input  logic [8*N-1:0] req_data_i,
  input  logic [N-1:0]   req_last_i,
  output logic [N-1:0]   req_ready_o,
  output logic [N-1:0]   grant_o,
  output logic [7:0]     tx_data_o,
  output logic           tx_valid_o,
  input  logic           busy_i,
  output logic           idle_o,
  output logic           timeout_o
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND      = 3'd1,
    START     = 3'd2,
    WAIT_DONE = 3'd3,
    RELEASE   = 3'd4
  } state_t;

  state_t           state, state_nx;
  logic [N-1:0]     grant_nx;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_nx;
  logic [IDX_W-1:0] gnt_idx, gnt_idx_nx;
  logic [7:0]       tx_data_nx;
  logic             tx_valid_nx;
  logic             timeout_nx;
  logic             last_r, last_nx;
  logic [7:0]       burst_cnt, burst_cnt_nx;
  logic [3:0]       start_cnt, start_cnt_nx;

  logic             arb_found;
  logic [IDX_W-1:0] arb_idx;
  logic [7:0]       sel_data;

  // Round-robin search: first valid requester starting at rr_ptr, wrapping mod N.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 0; i < N; i++) begin
      cand     = (int'(rr_ptr) + i) % N;
      cand_idx = IDX_W'(cand);
      if (!arb_found && req_valid_i[cand_idx]) begin
        arb_found = 1'b1;
        arb_idx   = cand_idx;
      end
    end
  end

  // Byte lane of the granted requester.
  always_comb begin
    sel_data = req_data_i[{gnt_idx, 3'b000} +: 8];
  end

  // Next-state and output decode; registered outputs hold unless a state updates them.
  always_comb begin
    state_nx     = state;
    grant_nx     = grant_o;
    gnt_idx_nx   = gnt_idx;
    rr_ptr_nx    = rr_ptr;
    tx_data_nx   = tx_data_o;
    tx_valid_nx  = 1'b0;
    timeout_nx   = 1'b0;
    last_nx      = last_r;
    burst_cnt_nx = burst_cnt;
    start_cnt_nx = start_cnt;
    req_ready_o  = '0;
    idle_o       = 1'b0;
    case (state)
      IDLE: begin
        idle_o = 1'b1;
        if (arb_found) begin
          grant_nx          = '0;
          grant_nx[arb_idx] = 1'b1;
          gnt_idx_nx        = arb_idx;
          state_nx          = SEND;
        end
      end
      SEND: begin
        // The requester holds valid while waiting, so the handshake completes here.
        req_ready_o  = grant_o;
        tx_data_nx   = sel_data;
        last_nx      = req_last_i[gnt_idx];
        burst_cnt_nx = burst_cnt + 8'd1;
        tx_valid_nx  = 1'b1;
        start_cnt_nx = '0;
        state_nx     = START;
      end
      START: begin
        if (busy_i) begin
          state_nx = WAIT_DONE;
        end else if (start_cnt == 4'(START_TO - 1)) begin
          // Transmitter never acknowledged the strobe; give up on this byte.
          timeout_nx = 1'b1;
          state_nx   = RELEASE;
        end else begin
          start_cnt_nx = start_cnt + 4'd1;
        end
      end
      WAIT_DONE: begin
        if (!busy_i) begin
          if (!last_r && (burst_cnt < 8'(MAX_BURST)) && req_valid_i[gnt_idx]) begin
            state_nx = SEND;
          end else begin
            state_nx = RELEASE;
          end
        end
      end
      RELEASE: begin
        grant_nx     = '0;
        rr_ptr_nx    = (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + IDX_W'(1);
        burst_cnt_nx = '0;
        state_nx     = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      grant_o    <= '0;
      gnt_idx    <= '0;
      rr_ptr     <= '0;
      tx_data_o  <= '0;
      tx_valid_o <= 1'b0;
      timeout_o  <= 1'b0;
      last_r     <= 1'b0;
      burst_cnt  <= '0;
      start_cnt  <= '0;
    end else begin
      state      <= state_nx;
      grant_o    <= grant_nx;
      gnt_idx    <= gnt_idx_nx;
      rr_ptr     <= rr_ptr_nx;
      tx_data_o  <= tx_data_nx;
      tx_valid_o <= tx_valid_nx;
      timeout_o  <= timeout_nx;
      last_r     <= last_nx;
      burst_cnt  <= burst_cnt_nx;
      start_cnt  <= start_cnt_nx;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queued requester models, a simple uart_tx busy
// model, and a scoreboard of expected (grant, byte) pairs per tx_valid_o strobe.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int N         = 4;
  localparam int MAX_BURST = 8;
  localparam int START_TO  = 4;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  wire  [N-1:0]   req_valid;
  wire  [8*N-1:0] req_data;
  wire  [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           busy = 1'b0;
  logic           idle;
  logic           timeout;

  int vec  = 0;
  int miss = 0;
  bit busy_en = 1'b1;
  bit flush   = 1'b0;
  int bcnt    = 0;

  typedef struct packed {
    logic [N-1:0] gnt;
    logic [7:0]   data;
  } exp_t;
  exp_t expq[$];

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N(N), .MAX_BURST(MAX_BURST), .START_TO(START_TO)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_last_i  (req_last),
    .req_ready_o (req_ready),
    .grant_o     (grant),
    .tx_data_o   (tx_data),
    .tx_valid_o  (tx_valid),
    .busy_i      (busy),
    .idle_o      (idle),
    .timeout_o   (timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Requester models: each presents the head of its byte queue until accepted.
  for (genvar k = 0; k < N; k++) begin : g_req
    logic [8:0] q[$];
    logic       pend = 1'b0;
    logic       v    = 1'b0;
    logic       l    = 1'b0;
    logic [7:0] d    = 8'h00;
    assign req_valid[k]      = v;
    assign req_last[k]       = l;
    assign req_data[8*k +: 8] = d;
    always begin
      @(posedge clk);
      #2;
      if (flush) begin
        q.delete();
        pend = 1'b0;
      end
      if (pend) begin
        if (q.size() > 0) void'(q.pop_front());
        pend = 1'b0;
      end
      if (v && req_ready[k]) pend = 1'b1;
      v = (q.size() > 0);
      d = v ? q[0][7:0] : 8'h00;
      l = v ? q[0][8] : 1'b0;
    end
  end

  // uart_tx stand-in: busy for a few cycles after each start strobe.
  always @(negedge clk) begin
    if (!rst_n) bcnt = 0;
    else if (tx_valid && busy_en) bcnt = 3;
    else if (bcnt > 0) bcnt--;
    busy = (bcnt > 0);
  end

  // Output monitor: protocol invariants and scoreboard compare on every strobe.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      chk("ready_only_granted", 32'(req_ready & ~grant), 32'd0);
      chk("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
      if (tx_valid) begin
        chk("sb_expected_tx", 32'(expq.size() > 0), 32'd1);
        if (expq.size() > 0) begin
          e = expq.pop_front();
          chk("tx_grant", 32'(grant), 32'(e.gnt));
          chk("tx_data", 32'(tx_data), 32'(e.data));
        end
      end
    end
  end

  task automatic push_req(input int k, input logic [7:0] data, input logic last);
    case (k)
      0: g_req[0].q.push_back({last, data});
      1: g_req[1].q.push_back({last, data});
      2: g_req[2].q.push_back({last, data});
      default: g_req[3].q.push_back({last, data});
    endcase
  endtask

  task automatic push_exp(input int k, input logic [7:0] data);
    exp_t e;
    e.gnt  = N'(1 << k);
    e.data = data;
    expq.push_back(e);
  endtask

  function automatic bit reqs_empty();
    return (g_req[0].q.size() == 0) && (g_req[1].q.size() == 0) &&
           (g_req[2].q.size() == 0) && (g_req[3].q.size() == 0);
  endfunction

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (!(idle && !busy && expq.size() == 0 && reqs_empty()) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < budget), 32'd1);
  endtask

  task automatic wait_tx(input string tag, input int budget);
    int n = 0;
    while (!tx_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < budget), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed hang expected summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, gaps, n, k;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Single byte from requester 2: latency of grant, ready and strobe.
    push_req(2, 8'hA5, 1'b1);
    push_exp(2, 8'hA5);
    @(posedge clk);
    @(negedge clk);
    chk("t1_c0_grant", 32'(grant), 32'd0);
    chk("t1_c0_idle", 32'(idle), 32'd1);
    @(negedge clk);
    chk("t1_c1_grant", 32'(grant), 32'b0100);
    chk("t1_c1_ready", 32'(req_ready), 32'b0100);
    chk("t1_c1_tx_valid", 32'(tx_valid), 32'd0);
    @(negedge clk);
    chk("t1_c2_tx_valid", 32'(tx_valid), 32'd1);
    chk("t1_c2_tx_data", 32'(tx_data), 32'hA5);
    chk("t1_c2_ready", 32'(req_ready), 32'd0);
    drain("t1_drain", 200);
    chk("t1_idle", 32'(idle), 32'd1);
    chk("t1_grant_clear", 32'(grant), 32'd0);

    // Pointer now 3: requester 3 beats requester 0.
    push_req(0, 8'h01, 1'b1);
    push_req(3, 8'h03, 1'b1);
    push_exp(3, 8'h03);
    push_exp(0, 8'h01);
    drain("t1b_drain", 300);

    // Fairness: 0 and 1 both busy, pointer at 1 -> alternate 1,0,1,0.
    push_req(0, 8'hB0, 1'b1);
    push_req(0, 8'hB1, 1'b1);
    push_req(1, 8'hC0, 1'b1);
    push_req(1, 8'hC1, 1'b1);
    push_exp(1, 8'hC0);
    push_exp(0, 8'hB0);
    push_exp(1, 8'hC1);
    push_exp(0, 8'hB1);
    drain("t2_drain", 400);

    // Burst of three from requester 3 under one continuous grant.
    push_req(3, 8'h11, 1'b0);
    push_req(3, 8'h22, 1'b0);
    push_req(3, 8'h33, 1'b1);
    push_exp(3, 8'h11);
    push_exp(3, 8'h22);
    push_exp(3, 8'h33);
    wait_tx("t3_first_tx", 50);
    p = 0; gaps = 0; n = 0;
    while (p < 2 && n < 100) begin
      @(negedge clk);
      n++;
      if (tx_valid) p++;
      if (grant !== 4'b1000) gaps++;
    end
    chk("t3_pulses", 32'(p), 32'd2);
    chk("t3_grant_held", 32'(gaps), 32'd0);
    drain("t3_drain", 200);

    // Burst cap: 20 bytes from 0 are split 8 / (1) / 8 / 4.
    for (int i = 0; i < 20; i++) push_req(0, 8'(8'h40 + i), (i == 19));
    push_req(1, 8'h90, 1'b1);
    for (int i = 0; i < 8; i++) push_exp(0, 8'(8'h40 + i));
    push_exp(1, 8'h90);
    for (int i = 8; i < 20; i++) push_exp(0, 8'(8'h40 + i));
    drain("t4_drain", 1500);

    // Timeout: transmitter never goes busy.
    busy_en = 1'b0;
    push_req(1, 8'h5A, 1'b1);
    push_req(2, 8'h6B, 1'b1);
    push_exp(1, 8'h5A);
    push_exp(2, 8'h6B);
    wait_tx("t5_first_tx", 50);
    k = 0;
    while (!timeout && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("t5_timeout_delay", 32'(k), 32'(START_TO));
    chk("t5_grant_at_timeout", 32'(grant), 32'b0010);
    @(negedge clk);
    chk("t5_timeout_pulse", 32'(timeout), 32'd0);
    drain("t5_drain", 300);
    busy_en = 1'b1;

    // Reset during WAIT_DONE, then fresh arbitration from pointer 0.
    push_req(3, 8'h01, 1'b0);
    push_req(3, 8'h02, 1'b0);
    push_req(3, 8'h03, 1'b1);
    push_exp(3, 8'h01);
    wait_tx("t6_first_tx", 50);
    @(negedge clk);
    flush = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_grant", 32'(grant), 32'd0);
    chk("t6_rst_ready", 32'(req_ready), 32'd0);
    chk("t6_rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("t6_rst_tx_data", 32'(tx_data), 32'd0);
    chk("t6_rst_idle", 32'(idle), 32'd1);
    expq.delete();
    repeat (2) @(negedge clk);
    flush = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    push_req(1, 8'h77, 1'b1);
    push_req(3, 8'h88, 1'b1);
    push_exp(1, 8'h77);
    push_exp(3, 8'h88);
    drain("t6_drain", 300);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares one uart_tx transmitter between N byte-stream requesters. It accepts bytes from requesters over valid/ready, drives the transmitter's tx_data/tx_valid strobe, and tracks the transmitter's busy flag to sequence frames. It sits between on-chip byte sources (CPU mailbox, debug logger, DMA) and the uart_tx instance. Bounded bursts prevent one requester from monopolising the line.

Parameters:
N, 4, number of requesters (2..8)
MAX_BURST, 8, maximum bytes sent per grant before forced re-arbitration (1..255)
START_TO, 4, cycles allowed after tx_valid_o for busy_i to rise (1..15)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  N  requester k has a byte pending; held until accepted
req_data_i  in  8*N  byte of requester k at bits [8k+7:8k]
req_last_i  in  N  byte of requester k is final byte of its burst
req_ready_o  out  N  one-hot accept strobe; handshake when valid & ready
grant_o  out  N  one-hot, requester owning the transmitter
tx_data_o  out  8  byte to uart_tx (tx_data_i)
tx_valid_o  out  1  one-cycle start strobe to uart_tx (tx_valid_i)
busy_i  in  1  uart_tx busy_o
idle_o  out  1  high in IDLE state
timeout_o  out  1  one-cycle pulse: busy_i never rose within START_TO

Behaviour:
- Reset (rst_ni=0, async, any state): state=IDLE, grant_o=0, req_ready_o=0, tx_data_o=0, tx_valid_o=0, timeout_o=0, rr_ptr=0, burst_cnt=0, idle_o=1.
- Arbitration (IDLE only): winner = first k with req_valid_i[k]=1 searching rr_ptr, rr_ptr+1, ... mod N. Winner registered into grant_o; go SEND. No valid -> stay IDLE.
- SEND (1 cycle): req_ready_o[g]=1 combinationally; valid is guaranteed high (requester rule). Latch req_data_i byte into tx_data_o, latch req_last_i[g] into last_r, burst_cnt++; tx_valid_o<=1; go START.
- START: tx_valid_o high only on first cycle of START. Count cycles; busy_i=1 -> WAIT_DONE. If START_TO cycles elapse without busy_i -> timeout_o pulse, go RELEASE (byte treated as dropped).
- WAIT_DONE: stay while busy_i=1. On busy_i=0: if last_r=0 and burst_cnt<MAX_BURST and req_valid_i[g]=1 -> SEND (same grant); else -> RELEASE.
- RELEASE (1 cycle): grant_o=0, rr_ptr=(g+1) mod N, burst_cnt=0; go IDLE.
- Latency: valid at cycle 0 in IDLE -> grant_o cycle 1, req_ready_o cycle 1, tx_valid_o cycle 2. Back-to-back burst bytes: busy_i fall at cycle t -> ready at t+1, tx_valid_o at t+2.
- grant_o is stable from arbitration through RELEASE; non-granted requesters never see ready.
- Valid requests arriving outside IDLE wait; no request is lost.
- tx_data_o holds last byte until next SEND.
- burst_cnt is 8 bits; MAX_BURST=1 gives byte-level round robin.
- Granted requester dropping valid mid-burst (not on a handshake) -> burst ends at next WAIT_DONE exit.
- busy_i high when entering IDLE is ignored by arbitration only if START later sees it; arbitration does not wait on busy_i (uart_tx busy is owned solely by this block).
- Reset asserted mid-frame: outputs clear immediately; uart_tx is reset by the same domain.

Test Plan:
- Single byte: req_valid_i[2]=1, data 0xA5, last=1 -> grant_o=0100 cycle 1, ready[2] cycle 1, tx_data_o=0xA5 with tx_valid_o pulse cycle 2; after busy_i fall, RELEASE, rr_ptr=3, idle_o=1.
- Fairness: requesters 0 and 1 valid continuously, last=1 each byte -> transmit order 0,1,0,1; no requester granted twice consecutively.
- Burst: requester 3 sends 3 bytes 0x11,0x22,0x33 (last on 0x33) -> single grant, three tx_valid_o pulses, then release.
- Burst cap: MAX_BURST=8, requester 0 streams 20 bytes, requester 1 valid -> 8 bytes of 0, then requester 1 granted, then 0 resumes.
- Timeout: busy_i tied 0 -> timeout_o pulse exactly START_TO cycles after tx_valid_o, grant released, next requester served.
- Reset mid-burst: drop rst_ni during WAIT_DONE -> grant_o, req_ready_o, tx_valid_o 0 asynchronously; after release, fresh arbitration from rr_ptr=0.
